// File: rtl/seq_det_pkg.sv
// Shared types for the programmable serial pattern detector: FSM states,
// derived length-field width and the latched configuration record.
package seq_det_pkg;

  localparam int DEF_PAT_W = 4;
  localparam int DEF_CNT_W = 8;

  // Length field must hold the value PAT_W itself, hence the extra bit.
  function automatic int len_width(input int pat_w);
    return $clog2(pat_w) + 1;
  endfunction

  localparam int DEF_LEN_W = len_width(DEF_PAT_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } state_t;

  // The record is sized for the default build; overriding PAT_W/CNT_W
  // requires changing DEF_* here as well.
  typedef struct packed {
    logic [DEF_PAT_W-1:0] pattern;
    logic [DEF_LEN_W-1:0] len;
    logic                 overlap;
  } match_cfg_t;

  typedef struct packed {
    match_cfg_t           mcfg;
    logic [DEF_CNT_W-1:0] target;
  } cfg_t;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Configuration, stream and result handshakes of seq_detect_ctrl.
interface seq_detect_ctrl_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W) + 1
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_target;
  logic             cfg_err;
  logic             start;
  logic             abort;
  logic             x;
  logic             x_valid;
  logic             detect;
  logic             busy;
  logic             done_valid;
  logic             done_ready;
  logic [CNT_W-1:0] done_count;
  logic             done_aborted;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
           start, abort, x, x_valid, done_ready,
    input  cfg_ready, cfg_err, detect, busy, done_valid, done_count, done_aborted
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
           start, abort, x, x_valid, done_ready,
    output cfg_ready, cfg_err, detect, busy, done_valid, done_count, done_aborted
  );
endinterface

// File: rtl/seq_match_core.sv
// History shift register plus fill counter; flags a match on the beat that
// completes the configured pattern (combinational, same cycle as the beat).
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = len_width(PAT_W)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       x,
  input  logic       x_valid,
  input  match_cfg_t cfg,
  output logic       match
);

  logic [PAT_W-2:0] hist_reg;
  logic [PAT_W-1:0] hist_next;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill_reg;
  logic [LEN_W-1:0] fill_inc;

  generate
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
      assign mask[gi] = (cfg.len > LEN_W'(gi));
    end
  endgenerate

  always_comb begin
    hist_next = {hist_reg, x};
    fill_inc  = (fill_reg == LEN_W'(PAT_W)) ? fill_reg : fill_reg + 1'b1;
    match     = x_valid && (fill_inc >= cfg.len) &&
                ((hist_next & mask) == (cfg.pattern & mask));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else if (clr) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else if (x_valid) begin
      hist_reg <= hist_next[PAT_W-2:0];
      // Non-overlap mode: the matched bits may not start the next match.
      fill_reg <= (match && !cfg.overlap) ? '0 : fill_inc;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Control FSM around seq_match_core: config handshake, run control,
// saturating match counter and result handshake.
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic              clk,
  input logic              reset,
  seq_detect_ctrl_if.slave bus
);

  localparam int LEN_W = len_width(PAT_W);

  state_t           state_reg, state_next;
  cfg_t             cfg_reg, cfg_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             detect_reg, detect_next;
  logic             aborted_reg, aborted_next;
  logic             cfg_err_reg, cfg_err_next;

  logic cfg_ready_w;
  logic cfg_fire;
  logic len_ok;
  logic core_clr;
  logic core_valid;
  logic match;

  assign cfg_ready_w = (state_reg == IDLE) || (state_reg == ARMED);
  assign cfg_fire    = bus.cfg_valid && cfg_ready_w;
  assign len_ok      = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(PAT_W));
  // A config offered alongside start takes precedence, so start is dropped.
  assign core_clr    = (state_reg == ARMED) && bus.start && !bus.cfg_valid;
  assign core_valid  = bus.x_valid && (state_reg == RUN);
  assign cnt_inc     = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;

  seq_match_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .clr     (core_clr),
    .x       (bus.x),
    .x_valid (core_valid),
    .cfg     (cfg_reg.mcfg),
    .match   (match)
  );

  always_comb begin
    state_next   = state_reg;
    cfg_next     = cfg_reg;
    cnt_next     = cnt_reg;
    aborted_next = aborted_reg;
    cfg_err_next = 1'b0;
    detect_next  = match;
    case (state_reg)
      IDLE, ARMED: begin
        if (cfg_fire) begin
          if (len_ok) begin
            cfg_next.mcfg.pattern = bus.cfg_pattern;
            cfg_next.mcfg.len     = bus.cfg_len;
            cfg_next.mcfg.overlap = bus.cfg_overlap;
            cfg_next.target       = bus.cfg_target;
            state_next            = ARMED;
          end else begin
            cfg_err_next = 1'b1;
          end
        end else if (core_clr) begin
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        if (match) begin
          cnt_next = cnt_inc;
        end
        // Reaching the target outranks a simultaneous abort.
        if (match && (cfg_reg.target != '0) && (cnt_inc == cfg_reg.target)) begin
          aborted_next = 1'b0;
          state_next   = REPORT;
        end else if (bus.abort) begin
          aborted_next = 1'b1;
          state_next   = REPORT;
        end
      end
      REPORT: begin
        if (bus.done_ready) begin
          state_next = ARMED;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cfg_reg     <= '0;
      cnt_reg     <= '0;
      detect_reg  <= 1'b0;
      aborted_reg <= 1'b0;
      cfg_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cfg_reg     <= cfg_next;
      cnt_reg     <= cnt_next;
      detect_reg  <= detect_next;
      aborted_reg <= aborted_next;
      cfg_err_reg <= cfg_err_next;
    end
  end

  assign bus.cfg_ready    = cfg_ready_w;
  assign bus.cfg_err      = cfg_err_reg;
  assign bus.detect       = detect_reg;
  assign bus.busy         = (state_reg == RUN);
  assign bus.done_valid   = (state_reg == REPORT);
  assign bus.done_count   = cnt_reg;
  assign bus.done_aborted = aborted_reg;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: a bit-level model queues expected
// detect cycles and run results; the DUT outputs are popped and compared.
module tb_seq_detect_ctrl;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  seq_detect_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int cnt;
    int ab;
  } done_t;

  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc      = 0;
  int    det_q[$];
  done_t done_q[$];

  logic [3:0] m_pat;
  logic [3:0] m_hist;
  int         m_len, m_fill, m_cnt, m_target;
  bit         m_ovl, m_armed, m_run;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.detect === 1'b1) begin
      if (det_q.size() == 0) begin
        check("det_unexpected", cyc, 0);
      end else begin
        int e;
        e = det_q.pop_front();
        check("det_cycle", cyc, e);
        $display("detect at cycle %0d", cyc);
      end
    end
  endtask

  task automatic send_cfg(input logic [3:0] pat, input int len, input bit ovl, input int tgt);
    bit legal;
    legal           = (len >= 1) && (len <= PAT_W);
    bus.cfg_valid   = 1'b1;
    bus.cfg_pattern = pat;
    bus.cfg_len     = 3'(len);
    bus.cfg_overlap = ovl;
    bus.cfg_target  = 8'(tgt);
    if (legal) begin
      m_pat = pat; m_len = len; m_ovl = ovl; m_target = tgt; m_armed = 1'b1;
    end
    tick();
    bus.cfg_valid = 1'b0;
    $display("cfg pat=%b len=%0d ovl=%0d tgt=%0d err=%0d", pat, len, ovl, tgt, bus.cfg_err);
    check("cfg_err", bus.cfg_err, !legal);
    tick();
    check("cfg_err_single", bus.cfg_err, 0);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    if (m_armed && !m_run) begin
      m_run = 1'b1; m_hist = '0; m_fill = 0; m_cnt = 0;
    end
    tick();
    bus.start = 1'b0;
    $display("start busy=%0d", bus.busy);
    check("busy_after_start", bus.busy, m_run);
  endtask

  task automatic beat(input bit b, input bit v, input bit ab);
    bit hit;
    bus.x       = b;
    bus.x_valid = v;
    bus.abort   = ab;
    if (m_run && v) begin
      m_hist = {m_hist[2:0], b};
      m_fill = (m_fill < PAT_W) ? m_fill + 1 : PAT_W;
      hit    = (m_fill >= m_len);
      for (int i = 0; i < m_len; i++)
        if (m_hist[i] != m_pat[i]) hit = 1'b0;
      if (hit) begin
        det_q.push_back(cyc + 1);
        if (m_cnt < 255) m_cnt++;
        if (!m_ovl) m_fill = 0;
        if (m_target != 0 && m_cnt == m_target) begin
          done_q.push_back('{m_cnt, 0});
          m_run = 1'b0;
        end
      end
    end
    if (m_run && ab) begin
      done_q.push_back('{m_cnt, 1});
      m_run = 1'b0;
    end
    tick();
    bus.x_valid = 1'b0;
    bus.abort   = 1'b0;
  endtask

  task automatic stream(input logic [6:0] bits);
    for (int i = 6; i >= 0; i--) beat(bits[i], 1'b1, 1'b0);
  endtask

  task automatic finish_run(input int hold);
    int    n;
    done_t e;
    n = 0;
    while (bus.done_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("done_valid", bus.done_valid, 1);
    if (done_q.size() == 0) begin
      check("done_unexpected", 1, 0);
      e = '{-1, -1};
    end else begin
      e = done_q.pop_front();
    end
    $display("done count=%0d aborted=%0d", bus.done_count, bus.done_aborted);
    check("done_count", bus.done_count, e.cnt);
    check("done_aborted", bus.done_aborted, e.ab);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", bus.done_valid, 1);
      check("hold_count", bus.done_count, e.cnt);
      check("hold_aborted", bus.done_aborted, e.ab);
    end
    bus.done_ready = 1'b1;
    tick();
    bus.done_ready = 1'b0;
    check("done_valid_drop", bus.done_valid, 0);
    check("cfg_ready_armed", bus.cfg_ready, 1);
    check("busy_after_report", bus.busy, 0);
    check("det_pending", det_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    bus.cfg_valid = 0; bus.cfg_pattern = 0; bus.cfg_len = 0; bus.cfg_overlap = 0;
    bus.cfg_target = 0; bus.start = 0; bus.abort = 0; bus.x = 0; bus.x_valid = 0;
    bus.done_ready = 0;
    m_armed = 0; m_run = 0; m_pat = 0; m_hist = 0;
    m_len = 0; m_fill = 0; m_cnt = 0; m_target = 0; m_ovl = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_cfg_ready", bus.cfg_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done_valid", bus.done_valid, 0);
    check("rst_detect", bus.detect, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    check("rst_done_count", bus.done_count, 0);
    reset = 1'b1;
    tick();

    // Illegal lengths rejected; start ignored from IDLE.
    send_cfg(4'b1011, 0, 1'b1, 2);
    send_cfg(4'b1011, 5, 1'b1, 2);
    do_start();
    check("idle_cfg_ready", bus.cfg_ready, 1);

    // Overlapping run to target 2, result held off for 10 cycles.
    send_cfg(4'b1011, 4, 1'b1, 2);
    do_start();
    stream(7'b1011011);
    finish_run(10);

    // Restart with retained config; gapped beats with x toggling while invalid.
    do_start();
    beat(1, 1, 0); beat(0, 0, 0); beat(1, 0, 0);
    beat(0, 1, 0); beat(1, 0, 0);
    beat(1, 1, 0); beat(0, 0, 0); beat(0, 0, 0); beat(1, 0, 0);
    beat(1, 1, 0); beat(0, 0, 0); beat(1, 0, 0);
    beat(0, 0, 1);
    finish_run(0);

    // Non-overlap, unlimited target, abort after the stream.
    send_cfg(4'b1011, 4, 1'b0, 0);
    do_start();
    stream(7'b1011011);
    beat(0, 0, 1);
    finish_run(0);

    // Abort on the target-reaching beat: target exit wins.
    send_cfg(4'b1011, 4, 1'b1, 1);
    do_start();
    beat(1, 1, 0); beat(0, 1, 0); beat(1, 1, 0); beat(1, 1, 1);
    finish_run(0);

    // Short pattern: only the low two bits of the pattern take part.
    send_cfg(4'b1101, 2, 1'b1, 0);
    do_start();
    stream(7'b0101101);
    beat(0, 0, 1);
    finish_run(0);

    // Reset mid-run after two matches.
    send_cfg(4'b1011, 4, 1'b1, 0);
    do_start();
    stream(7'b1011011);
    #2;
    reset = 1'b0;
    #1;
    m_armed = 0; m_run = 0;
    det_q.delete();
    done_q.delete();
    $display("reset asserted mid-run");
    check("mid_rst_detect", bus.detect, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done_valid", bus.done_valid, 0);
    check("mid_rst_done_count", bus.done_count, 0);
    check("mid_rst_cfg_ready", bus.cfg_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    tick();
    do_start();
    tick();
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_done_valid", bus.done_valid, 0);

    check("det_q_empty", det_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
